// File: rtl/mem_req_scheduler_if.sv
// Request/response bus of the memory request scheduler: two requesters in,
// one memory port out. The scheduler takes the slave modport, the environment the master.
interface mem_req_scheduler_if;
  logic        io_in_0_valid, io_in_0_ready;
  logic [2:0]  io_in_0_bits_opcode;
  logic [31:0] io_in_0_bits_size, io_in_0_bits_address, io_in_0_bits_data;
  logic        io_in_1_valid, io_in_1_ready;
  logic [2:0]  io_in_1_bits_opcode;
  logic [31:0] io_in_1_bits_size, io_in_1_bits_address, io_in_1_bits_data;
  logic        io_out_valid, io_out_ready;
  logic [2:0]  io_out_bits_opcode;
  logic [31:0] io_out_bits_size, io_out_bits_address, io_out_bits_data;
  logic        io_mem_resp_valid, io_mem_resp_ready;
  logic [31:0] io_mem_resp_data;
  logic        io_resp_0_valid, io_resp_0_ready;
  logic        io_resp_1_valid, io_resp_1_ready;
  logic [31:0] io_resp_data;
  logic        io_timeout;

  modport slave (
    input  io_in_0_valid, io_in_0_bits_opcode, io_in_0_bits_size, io_in_0_bits_address, io_in_0_bits_data,
    input  io_in_1_valid, io_in_1_bits_opcode, io_in_1_bits_size, io_in_1_bits_address, io_in_1_bits_data,
    input  io_out_ready, io_mem_resp_valid, io_mem_resp_data, io_resp_0_ready, io_resp_1_ready,
    output io_in_0_ready, io_in_1_ready, io_out_valid,
    output io_out_bits_opcode, io_out_bits_size, io_out_bits_address, io_out_bits_data,
    output io_mem_resp_ready, io_resp_0_valid, io_resp_1_valid, io_resp_data, io_timeout
  );

  modport master (
    output io_in_0_valid, io_in_0_bits_opcode, io_in_0_bits_size, io_in_0_bits_address, io_in_0_bits_data,
    output io_in_1_valid, io_in_1_bits_opcode, io_in_1_bits_size, io_in_1_bits_address, io_in_1_bits_data,
    output io_out_ready, io_mem_resp_valid, io_mem_resp_data, io_resp_0_ready, io_resp_1_ready,
    input  io_in_0_ready, io_in_1_ready, io_out_valid,
    input  io_out_bits_opcode, io_out_bits_size, io_out_bits_address, io_out_bits_data,
    input  io_mem_resp_ready, io_resp_0_valid, io_resp_1_valid, io_resp_data, io_timeout
  );
endinterface

// File: rtl/mem_req_scheduler.sv
// Two-requester, single-outstanding memory request scheduler with response timeout.
// MEM_SCHED_RR_EN selects round-robin arbitration; default is fixed priority to requester 0.
module mem_req_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                clock,
  input logic                reset,
  mem_req_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;
  typedef struct packed {
    logic [2:0]  opcode;
    logic [31:0] size;
    logic [31:0] address;
    logic [31:0] data;
  } req_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  req_t        req_q, req_sel;
  logic        owner_q;
  logic [31:0] rdata_q;
  logic [15:0] cnt_q;
  logic        out_valid_q, mem_ready_q, resp0_q, resp1_q, timeout_q;
  logic        gnt, accept, owner_ready;

`ifdef MEM_SCHED_RR_EN
  logic last_q;
  // On contention the requester that did not win last time goes first.
  always_comb gnt = (bus.io_in_0_valid && bus.io_in_1_valid) ? ~last_q : bus.io_in_1_valid;

  always_ff @(posedge clock) begin
    if (reset)       last_q <= 1'b1;
    else if (accept) last_q <= gnt;
  end
`else
  always_comb gnt = ~bus.io_in_0_valid;
`endif

  assign accept = (state_q == IDLE) && (bus.io_in_0_valid || bus.io_in_1_valid);
  assign bus.io_in_0_ready = (state_q == IDLE) && bus.io_in_0_valid && !gnt;
  assign bus.io_in_1_ready = (state_q == IDLE) && bus.io_in_1_valid && gnt;
  assign owner_ready = owner_q ? bus.io_resp_1_ready : bus.io_resp_0_ready;

  always_comb begin
    req_sel = gnt ? req_t'{bus.io_in_1_bits_opcode, bus.io_in_1_bits_size,
                           bus.io_in_1_bits_address, bus.io_in_1_bits_data}
                  : req_t'{bus.io_in_0_bits_opcode, bus.io_in_0_bits_size,
                           bus.io_in_0_bits_address, bus.io_in_0_bits_data};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      req_q       <= '0;
      owner_q     <= 1'b0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      mem_ready_q <= 1'b0;
      resp0_q     <= 1'b0;
      resp1_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          req_q       <= req_sel;
          owner_q     <= gnt;
          out_valid_q <= 1'b1;
          state_q     <= ISSUE;
        end
        ISSUE: if (bus.io_out_ready) begin
          out_valid_q <= 1'b0;
          mem_ready_q <= 1'b1;
          cnt_q       <= '0;
          state_q     <= WAIT;
        end
        WAIT: begin
          // A response arriving on the last counted cycle beats the timeout.
          if (bus.io_mem_resp_valid || cnt_q == CNT_LAST) begin
            rdata_q     <= bus.io_mem_resp_valid ? bus.io_mem_resp_data : 32'h0;
            timeout_q   <= !bus.io_mem_resp_valid;
            mem_ready_q <= 1'b0;
            resp0_q     <= !owner_q;
            resp1_q     <= owner_q;
            state_q     <= DELIVER;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DELIVER: if (owner_ready) begin
          resp0_q <= 1'b0;
          resp1_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.io_out_valid        = out_valid_q;
  assign bus.io_out_bits_opcode  = req_q.opcode;
  assign bus.io_out_bits_size    = req_q.size;
  assign bus.io_out_bits_address = req_q.address;
  assign bus.io_out_bits_data    = req_q.data;
  assign bus.io_mem_resp_ready   = mem_ready_q;
  assign bus.io_resp_0_valid     = resp0_q;
  assign bus.io_resp_1_valid     = resp1_q;
  assign bus.io_resp_data        = rdata_q;
  assign bus.io_timeout          = timeout_q;
endmodule

// File: tb/tb_mem_req_scheduler.sv
// Directed bench for mem_req_scheduler (TIMEOUT_CYCLES=4); expected grant order
// follows MEM_SCHED_RR_EN when the bench is built with it.
module tb_mem_req_scheduler;
  logic clock, reset;
  int checks, errors;
  int exp_g;

  mem_req_scheduler_if bus();
  mem_req_scheduler #(.TIMEOUT_CYCLES(4)) dut (.clock(clock), .reset(reset), .bus(bus));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1;
    bus.io_in_0_valid = 0; bus.io_in_0_bits_opcode = 0; bus.io_in_0_bits_size = 0;
    bus.io_in_0_bits_address = 0; bus.io_in_0_bits_data = 0;
    bus.io_in_1_valid = 0; bus.io_in_1_bits_opcode = 0; bus.io_in_1_bits_size = 0;
    bus.io_in_1_bits_address = 0; bus.io_in_1_bits_data = 0;
    bus.io_out_ready = 0; bus.io_mem_resp_valid = 0; bus.io_mem_resp_data = 0;
    bus.io_resp_0_ready = 0; bus.io_resp_1_ready = 0;
    tick(); tick();

    // Reset state
    chk("rst_out_valid", 32'(bus.io_out_valid), 32'd0);
    chk("rst_mem_ready", 32'(bus.io_mem_resp_ready), 32'd0);
    chk("rst_resp0", 32'(bus.io_resp_0_valid), 32'd0);
    chk("rst_resp1", 32'(bus.io_resp_1_valid), 32'd0);
    chk("rst_timeout", 32'(bus.io_timeout), 32'd0);
    chk("rst_addr", bus.io_out_bits_address, 32'd0);
    chk("rst_rdata", bus.io_resp_data, 32'd0);
    reset = 1'b0;

    // Single Get from requester 0, response in the third WAIT cycle
    bus.io_in_0_valid = 1; bus.io_in_0_bits_opcode = 3'd4; bus.io_in_0_bits_size = 32'd4;
    bus.io_in_0_bits_address = 32'h1000; bus.io_in_0_bits_data = 32'h0;
    #1;
    chk("s1_in0_ready", 32'(bus.io_in_0_ready), 32'd1);
    chk("s1_in1_ready", 32'(bus.io_in_1_ready), 32'd0);
    tick();
    bus.io_in_0_valid = 0;
    chk("s1_out_valid", 32'(bus.io_out_valid), 32'd1);
    chk("s1_out_addr", bus.io_out_bits_address, 32'h1000);
    chk("s1_out_op", 32'(bus.io_out_bits_opcode), 32'd4);
    chk("s1_out_size", bus.io_out_bits_size, 32'd4);
    bus.io_out_ready = 1;
    tick();
    bus.io_out_ready = 0;
    chk("s1_wait_mem_ready", 32'(bus.io_mem_resp_ready), 32'd1);
    chk("s1_wait_out_valid", 32'(bus.io_out_valid), 32'd0);
    tick(); tick();
    bus.io_mem_resp_valid = 1; bus.io_mem_resp_data = 32'hDEADBEEF;
    tick();
    bus.io_mem_resp_valid = 0;
    chk("s1_resp0", 32'(bus.io_resp_0_valid), 32'd1);
    chk("s1_resp1", 32'(bus.io_resp_1_valid), 32'd0);
    chk("s1_rdata", bus.io_resp_data, 32'hDEADBEEF);
    chk("s1_timeout", 32'(bus.io_timeout), 32'd0);
    chk("s1_deliver_mem_ready", 32'(bus.io_mem_resp_ready), 32'd0);
    bus.io_resp_0_ready = 1;
    tick();
    bus.io_resp_0_ready = 0;
    chk("s1_idle_resp0", 32'(bus.io_resp_0_valid), 32'd0);

    // Both requesters valid continuously, back-to-back 4-cycle transactions
    reset = 1; tick(); reset = 0;
    bus.io_in_0_valid = 1; bus.io_in_0_bits_address = 32'h100;
    bus.io_in_1_valid = 1; bus.io_in_1_bits_address = 32'h200;
    bus.io_out_ready = 1; bus.io_mem_resp_valid = 1;
    bus.io_resp_0_ready = 1; bus.io_resp_1_ready = 1;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_SCHED_RR_EN
      exp_g = i % 2;
`else
      exp_g = 0;
`endif
      bus.io_mem_resp_data = 32'h5000 + 32'(i);
      #1;
      chk("s2_in1_ready", 32'(bus.io_in_1_ready), 32'(exp_g));
      chk("s2_in0_ready", 32'(bus.io_in_0_ready), 32'(1 - exp_g));
      tick();
      chk("s2_issue_addr", bus.io_out_bits_address, (exp_g == 1) ? 32'h200 : 32'h100);
      tick(); tick();
      chk("s2_resp1", 32'(bus.io_resp_1_valid), 32'(exp_g));
      chk("s2_resp0", 32'(bus.io_resp_0_valid), 32'(1 - exp_g));
      chk("s2_rdata", bus.io_resp_data, 32'h5000 + 32'(i));
      tick();
    end
    bus.io_in_0_valid = 0; bus.io_in_1_valid = 0;
    bus.io_out_ready = 0; bus.io_mem_resp_valid = 0;
    bus.io_resp_0_ready = 0; bus.io_resp_1_ready = 0;

    // Requester 1 Put, memory stalls 5 cycles, then no response -> timeout
    bus.io_in_1_valid = 1; bus.io_in_1_bits_opcode = 3'd1; bus.io_in_1_bits_size = 32'd8;
    bus.io_in_1_bits_address = 32'hABCD0000; bus.io_in_1_bits_data = 32'h12345678;
    #1;
    chk("s3_in1_ready", 32'(bus.io_in_1_ready), 32'd1);
    tick();
    bus.io_in_0_valid = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("s3_stall_valid", 32'(bus.io_out_valid), 32'd1);
      chk("s3_stall_addr", bus.io_out_bits_address, 32'hABCD0000);
      chk("s3_stall_data", bus.io_out_bits_data, 32'h12345678);
      chk("s3_stall_in_ready", {30'd0, bus.io_in_1_ready, bus.io_in_0_ready}, 32'd0);
      tick();
    end
    chk("s3_op", 32'(bus.io_out_bits_opcode), 32'd1);
    bus.io_in_0_valid = 0; bus.io_in_1_valid = 0;
    bus.io_out_ready = 1;
    tick();
    bus.io_out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      chk("s4_wait_no_timeout", 32'(bus.io_timeout), 32'd0);
      chk("s4_wait_mem_ready", 32'(bus.io_mem_resp_ready), 32'd1);
      tick();
    end
    chk("s4_timeout_pulse", 32'(bus.io_timeout), 32'd1);
    chk("s4_resp1", 32'(bus.io_resp_1_valid), 32'd1);
    chk("s4_resp0", 32'(bus.io_resp_0_valid), 32'd0);
    chk("s4_rdata_zero", bus.io_resp_data, 32'h0);
    tick();
    chk("s4_timeout_once", 32'(bus.io_timeout), 32'd0);
    chk("s4_resp1_held", 32'(bus.io_resp_1_valid), 32'd1);
    bus.io_resp_1_ready = 1;
    tick();
    bus.io_resp_1_ready = 0;
    chk("s4_idle_resp1", 32'(bus.io_resp_1_valid), 32'd0);

    // Response on the timeout cycle wins
    bus.io_in_0_valid = 1; bus.io_in_0_bits_address = 32'h2000; bus.io_out_ready = 1;
    tick();
    bus.io_in_0_valid = 0;
    tick();
    bus.io_out_ready = 0;
    tick(); tick(); tick();
    bus.io_mem_resp_valid = 1; bus.io_mem_resp_data = 32'hCAFEF00D;
    tick();
    bus.io_mem_resp_valid = 0;
    chk("s5_timeout", 32'(bus.io_timeout), 32'd0);
    chk("s5_resp0", 32'(bus.io_resp_0_valid), 32'd1);
    chk("s5_rdata", bus.io_resp_data, 32'hCAFEF00D);
    bus.io_resp_0_ready = 1;
    tick();
    bus.io_resp_0_ready = 0;

    // Reset while in WAIT abandons the transaction
    bus.io_in_0_valid = 1; bus.io_in_0_bits_address = 32'h3000; bus.io_out_ready = 1;
    tick();
    bus.io_in_0_valid = 0;
    tick();
    bus.io_out_ready = 0;
    chk("s6_in_wait", 32'(bus.io_mem_resp_ready), 32'd1);
    reset = 1;
    tick();
    reset = 0;
    chk("s6_valids", {28'd0, bus.io_out_valid, bus.io_mem_resp_ready,
                      bus.io_resp_1_valid, bus.io_resp_0_valid}, 32'd0);
    bus.io_in_1_valid = 1; bus.io_in_1_bits_address = 32'h4000;
    #1;
    chk("s6_accept_now", 32'(bus.io_in_1_ready), 32'd1);
    tick();
    bus.io_in_1_valid = 0;
    chk("s6_issue_addr", bus.io_out_bits_address, 32'h4000);
    bus.io_out_ready = 1;
    tick();
    bus.io_out_ready = 0;
    bus.io_mem_resp_valid = 1; bus.io_mem_resp_data = 32'h77;
    tick();
    bus.io_mem_resp_valid = 0;
    chk("s6_resp1", 32'(bus.io_resp_1_valid), 32'd1);
    chk("s6_resp0_none", 32'(bus.io_resp_0_valid), 32'd0);
    bus.io_resp_1_ready = 1;
    tick();
    bus.io_resp_1_ready = 0;

    // Stray response while IDLE is ignored
    bus.io_mem_resp_valid = 1; bus.io_mem_resp_data = 32'h55;
    #1;
    chk("s7_mem_ready", 32'(bus.io_mem_resp_ready), 32'd0);
    tick(); tick();
    bus.io_mem_resp_valid = 0;
    chk("s7_resp_valids", {30'd0, bus.io_resp_1_valid, bus.io_resp_0_valid}, 32'd0);
    chk("s7_rdata_kept", bus.io_resp_data, 32'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_req_scheduler.md
MEM_REQ_SCHEDULER -- requirements
Module: mem_req_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: WAIT-state cycles before a missing response is declared timed out; legal range 2..65535.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset:
clock  in  1  sole clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
REQ-003 The block SHALL expose these ports; N in {0,1}, one line per port family:
io_in_N_valid  in  1  requester N has a request
io_in_N_ready  out  1  request from requester N accepted this cycle
io_in_N_bits_opcode  in  3  request opcode (4 = Get, other = Put)
io_in_N_bits_size  in  32  request size
io_in_N_bits_address  in  32  request address
io_in_N_bits_data  in  32  write data
io_out_valid  out  1  request to memory valid
io_out_ready  in  1  memory accepts request
io_out_bits_opcode / _size / _address / _data  out  3/32/32/32  registered request payload
io_mem_resp_valid  in  1  memory response valid
io_mem_resp_ready  out  1  scheduler accepts response
io_mem_resp_data  in  32  response data
io_resp_N_valid  out  1  response for requester N valid
io_resp_N_ready  in  1  requester N accepts response
io_resp_data  out  32  response data, shared by both requesters
io_timeout  out  1  one-cycle pulse on response timeout

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE, WAIT and DELIVER, with one transaction in flight at most.
REQ-005 In IDLE, exactly the granted valid requester SHALL see io_in_N_ready=1; on that handshake the block SHALL latch the payload and the owner index and go to ISSUE. With no valid requester, it SHALL stay in IDLE.
REQ-006 In ISSUE, io_out_valid SHALL be 1, with io_out_bits_* driven from the latched payload, held stable until io_out_ready=1; then the FSM SHALL go to WAIT and clear the timeout counter.
REQ-007 In WAIT, io_mem_resp_ready SHALL be 1; on io_mem_resp_valid the block SHALL latch the data and go to DELIVER.
REQ-008 In WAIT without a response, the counter SHALL increment each cycle; when it reaches TIMEOUT_CYCLES-1, the block SHALL pulse io_timeout for one cycle, latch data 32'h0 and go to DELIVER.
REQ-009 If a response and the timeout coincide, the response SHALL win and io_timeout SHALL stay 0.
REQ-010 In DELIVER, io_resp_<owner>_valid SHALL be 1 and the other io_resp_*_valid SHALL be 0; on io_resp_<owner>_ready the FSM SHALL return to IDLE.
REQ-011 io_mem_resp_ready SHALL be 0 outside WAIT; stray responses SHALL NOT be accepted.
REQ-012 io_in_N_ready SHALL be 0 outside IDLE.
REQ-013 Minimum latency SHALL be: request accept to io_out_valid, 1 cycle; response accept to io_resp_N_valid, 1 cycle; back-to-back transactions, 4 cycles each.
REQ-014 Opcode, size, address and data SHALL pass unmodified; the block SHALL NOT interpret the opcode.

Reset
REQ-015 On reset the block SHALL enter IDLE; io_out_valid, io_mem_resp_ready, io_resp_0_valid, io_resp_1_valid and io_timeout SHALL be 0; payload, response registers and counter SHALL be 0; the last-grant register SHALL be 1.
REQ-016 Reset asserted mid-transaction SHALL abandon the transaction with no response delivered; the next cycle after reset deasserts SHALL behave as IDLE.

Configuration
REQ-017 Macro MEM_SCHED_RR_EN defined: round-robin arbitration; when both requesters are valid, the one not in the last-grant register SHALL win; the last-grant register SHALL update on every accept.
REQ-018 MEM_SCHED_RR_EN undefined: fixed priority, requester 0 always wins; the last-grant register SHALL be absent.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Single request: in0 Get, addr 0x1000; io_out_ready=1; response 0xDEADBEEF after 3 cycles -> io_resp_0_valid with io_resp_data=0xDEADBEEF; io_resp_1_valid stays 0.
- Both requesters valid continuously, RR defined -> grants 0,1,0,1; RR undefined -> grants 0,0,0,0.
- io_out_ready held low 5 cycles -> io_out_valid stays high with the payload stable; io_in_*_ready stays 0.
- TIMEOUT_CYCLES=4, no response -> io_timeout pulses exactly once, 4 cycles after entering WAIT; owner gets io_resp_data=0x0.
- Response on the timeout cycle -> io_timeout=0; response data delivered. Reset asserted in WAIT -> after reset, all valids 0 and a new request is accepted immediately.
- io_mem_resp_valid pulsed while in IDLE -> io_mem_resp_ready=0 and no io_resp_*_valid.
